// File: rtl/axi_pkg.sv
// Shared AXI constants and state encodings used by the SRAM responder.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [3:0] {
    R_IDLE = 4'b0001,
    R_WAIT = 4'b0010,
    R_DATA = 4'b0100
  } rd_state_t;

  typedef enum logic [3:0] {
    W_IDLE = 4'b0001,
    W_DATA = 4'b0010,
    W_RESP = 4'b0100
  } wr_state_t;

  // Byte increment between consecutive beats of an INCR burst.
  function automatic logic [31:0] beat_step(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle between the data-cache master and the SRAM responder.
interface axi_sram_slave_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/sram_1r1w.sv
// Word array with an asynchronous read port and a synchronous byte-enabled write port.
module sram_1r1w #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [WORDS];

  assign rdata = mem[raddr];

  // Merge the enabled byte lanes into the addressed word; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word-addressed SRAM; independent read and write
// engines, each holding a single outstanding transaction.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MEM_WORDS = 4096,
  parameter int          RD_DELAY  = 2
) (
  input logic             aclk,
  input logic             aresetn,
  axi_sram_slave_if.slave bus
);

  localparam int         AW           = $clog2(MEM_WORDS);
  localparam logic [3:0] RD_DELAY_CNT = 4'(RD_DELAY);

  rd_state_t   rd_state;
  logic [31:0] rd_addr;
  logic [3:0]  rd_len;
  logic [3:0]  rd_beat;
  logic [3:0]  rd_cnt;
  logic [2:0]  rd_size;

  wr_state_t   wr_state;
  logic [31:0] wr_addr;
  logic [3:0]  wr_len;
  logic [3:0]  wr_beat;
  logic [2:0]  wr_size;
  logic        wr_err;

  logic [31:0] mem_rdata;
  logic        w_fire;
  logic        w_beat_err;
  logic        mem_we;
  logic        unused_sigs;

  function automatic logic addr_ok(input logic [31:0] a);
    return ((a - ADDR_BASE) >> 2) < 32'(MEM_WORDS);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - ADDR_BASE) >> 2);
  endfunction

  function automatic logic [1:0] resp_for(input logic [31:0] a);
    return addr_ok(a) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  // Burst type and write ID carry no meaning here: every burst is treated as INCR.
  assign unused_sigs = ^{bus.wid, bus.arburst == BURST_INCR, bus.awburst == BURST_INCR};

  assign w_fire     = (wr_state == W_DATA) && bus.wvalid && bus.wready;
  assign w_beat_err = !addr_ok(wr_addr) || (bus.wlast != (wr_beat == wr_len));
  assign mem_we     = w_fire && addr_ok(wr_addr);

  // Out-of-range beats and idle cycles present zero data.
  assign bus.rdata = (bus.rvalid && bus.rresp == RESP_OKAY) ? mem_rdata : 32'd0;

  sram_1r1w #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk   (aclk),
    .raddr (word_idx(rd_addr)),
    .rdata (mem_rdata),
    .we    (mem_we),
    .waddr (word_idx(wr_addr)),
    .wstrb (bus.wstrb),
    .wdata (bus.wdata)
  );

  // Read engine: accept AR, wait the configured delay, then stream beats.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state    <= R_IDLE;
      rd_addr     <= '0;
      rd_len      <= '0;
      rd_beat     <= '0;
      rd_cnt      <= '0;
      rd_size     <= '0;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rlast   <= 1'b0;
      bus.rresp   <= RESP_OKAY;
      bus.rid     <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          bus.arready <= 1'b1;
          if (bus.arvalid && bus.arready) begin
            bus.arready <= 1'b0;
            bus.rid     <= bus.arid;
            rd_addr     <= bus.araddr;
            rd_len      <= bus.arlen;
            rd_size     <= bus.arsize;
            rd_beat     <= '0;
            rd_cnt      <= RD_DELAY_CNT;
            if (RD_DELAY == 0) begin
              rd_state   <= R_DATA;
              bus.rvalid <= 1'b1;
              bus.rlast  <= (bus.arlen == 4'd0);
              bus.rresp  <= resp_for(bus.araddr);
            end else begin
              rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rd_cnt <= 4'd1) begin
            rd_state   <= R_DATA;
            bus.rvalid <= 1'b1;
            bus.rlast  <= (rd_len == 4'd0);
            bus.rresp  <= resp_for(rd_addr);
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (bus.rready) begin
            if (bus.rlast) begin
              rd_state    <= R_IDLE;
              bus.rvalid  <= 1'b0;
              bus.rlast   <= 1'b0;
              bus.rresp   <= RESP_OKAY;
              bus.arready <= 1'b1;
            end else begin
              rd_addr   <= rd_addr + beat_step(rd_size);
              rd_beat   <= rd_beat + 4'd1;
              bus.rlast <= ((rd_beat + 4'd1) == rd_len);
              bus.rresp <= resp_for(rd_addr + beat_step(rd_size));
            end
          end
        end
        default: begin
          rd_state    <= R_IDLE;
          bus.arready <= 1'b0;
          bus.rvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Write engine: accept AW, absorb the counted W beats, then return one B.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state    <= W_IDLE;
      wr_addr     <= '0;
      wr_len      <= '0;
      wr_beat     <= '0;
      wr_size     <= '0;
      wr_err      <= 1'b0;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
      bus.bid     <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          bus.awready <= 1'b1;
          if (bus.awvalid && bus.awready) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b1;
            bus.bid     <= bus.awid;
            wr_addr     <= bus.awaddr;
            wr_len      <= bus.awlen;
            wr_size     <= bus.awsize;
            wr_beat     <= '0;
            wr_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            wr_err <= wr_err | w_beat_err;
            if (wr_beat == wr_len) begin
              wr_state   <= W_RESP;
              bus.wready <= 1'b0;
              bus.bvalid <= 1'b1;
              bus.bresp  <= (wr_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              wr_addr <= wr_addr + beat_step(wr_size);
              wr_beat <= wr_beat + 4'd1;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            wr_state    <= W_IDLE;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= RESP_OKAY;
            wr_err      <= 1'b0;
            bus.awready <= 1'b1;
          end
        end
        default: begin
          wr_state    <= W_IDLE;
          bus.awready <= 1'b0;
          bus.wready  <= 1'b0;
          bus.bvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: a transaction table drives write and
// read bursts, read beats are checked against a queue of expected beats built
// from a reference memory model when each AR is issued.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WORDS = 4096;
  localparam int          DELAY = 2;

  typedef struct {
    logic        wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [31:0] data0;
    logic [3:0]  strb;
    int          bad_last;
    logic [1:0]  exp_resp;
    logic        chk_first;
    logic [31:0] exp_first;
    logic        stall;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } exp_t;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  exp_t        rdq[$];
  logic [31:0] model [WORDS];
  int          checks   = 0;
  int          failures = 0;

  axi_sram_slave_if bus();

  axi_sram_slave #(
    .ADDR_BASE (BASE),
    .MEM_WORDS (WORDS),
    .RD_DELAY  (DELAY)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  // Free-running 100 MHz clock.
  always #5 aclk = ~aclk;

  // Hard stop in case a handshake never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got timeout, expected handshake", name);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idleInputs();
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
  endtask

  function automatic logic inRange(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(4 * WORDS);
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    if (inRange(a)) begin
      w = int'((a - BASE) / 4);
      for (int l = 0; l < 4; l++) begin
        if (s[l]) model[w][8*l +: 8] = d[8*l +: 8];
      end
    end
  endtask

  function automatic vec_t mkW(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [31:0] data0, input logic [3:0] strb,
                               input int bad_last, input logic [1:0] exp_resp);
    vec_t v;
    v.wr = 1'b1; v.id = id; v.addr = addr; v.len = len; v.size = size; v.data0 = data0;
    v.strb = strb; v.bad_last = bad_last; v.exp_resp = exp_resp;
    v.chk_first = 1'b0; v.exp_first = '0; v.stall = 1'b0;
    return v;
  endfunction

  function automatic vec_t mkR(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic stall, input logic chk_first, input logic [31:0] exp_first,
                               input logic [1:0] exp_resp);
    vec_t v;
    v.wr = 1'b0; v.id = id; v.addr = addr; v.len = len; v.size = 3'd2; v.data0 = '0;
    v.strb = '0; v.bad_last = -1; v.exp_resp = exp_resp;
    v.chk_first = chk_first; v.exp_first = exp_first; v.stall = stall;
    return v;
  endfunction

  task automatic writeBurst(input vec_t v);
    int          n;
    logic [31:0] a;
    logic [31:0] d;
    bus.awid = v.id; bus.awaddr = v.addr; bus.awlen = v.len; bus.awsize = v.size;
    bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin tick(); n++; end
    if (!bus.awready) begin
      timeoutFail("aw_handshake");
      bus.awvalid = 1'b0;
      return;
    end
    tick();
    bus.awvalid = 1'b0;
    checkOutput("awready_low_after_aw", 32'(bus.awready), 32'd0);
    checkOutput("wready_after_aw", 32'(bus.wready), 32'd1);
    for (int b = 0; b <= int'(v.len); b++) begin
      a = v.addr + (32'(b) << v.size);
      d = v.data0 + 32'(b);
      bus.wid = v.id; bus.wdata = d; bus.wstrb = v.strb;
      bus.wlast = (b == int'(v.len)) ^ (b == v.bad_last);
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 50) begin tick(); n++; end
      if (!bus.wready) begin
        timeoutFail("w_handshake");
        bus.wvalid = 1'b0;
        return;
      end
      tick();
      modelWrite(a, d, v.strb);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    checkOutput("bvalid_after_last_w", 32'(bus.bvalid), 32'd1);
    checkOutput("bid", 32'(bus.bid), 32'(v.id));
    checkOutput("bresp", 32'(bus.bresp), 32'(v.exp_resp));
    checkOutput("wready_low_in_resp", 32'(bus.wready), 32'd0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    checkOutput("bvalid_cleared", 32'(bus.bvalid), 32'd0);
    checkOutput("awready_after_b", 32'(bus.awready), 32'd1);
  endtask

  task automatic resetMidBurst();
    bus.rready = 1'b1;
    aresetn    = 1'b0;
    tick();
    bus.rready = 1'b0;
    checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("rst_arready", 32'(bus.arready), 32'd0);
    checkOutput("rst_awready", 32'(bus.awready), 32'd0);
    aresetn = 1'b1;
    tick();
    checkOutput("rst_release_arready", 32'(bus.arready), 32'd1);
    checkOutput("rst_release_awready", 32'(bus.awready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      bus.rready = 1'b1;
      checkOutput("no_stray_r_beat", 32'(bus.rvalid), 32'd0);
      tick();
    end
    bus.rready = 1'b0;
  endtask

  task automatic readBurst(input vec_t v, input int abortAt);
    int          n;
    int          done;
    logic        toggle;
    logic [31:0] a;
    exp_t        e;
    for (int b = 0; b <= int'(v.len); b++) begin
      a = v.addr + (32'(b) << v.size);
      e.data = inRange(a) ? model[int'((a - BASE) / 4)] : 32'd0;
      e.resp = inRange(a) ? RESP_OKAY : RESP_SLVERR;
      e.last = (b == int'(v.len));
      e.id   = v.id;
      rdq.push_back(e);
    end
    bus.arid = v.id; bus.araddr = v.addr; bus.arlen = v.len; bus.arsize = v.size;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin tick(); n++; end
    if (!bus.arready) begin
      timeoutFail("ar_handshake");
      bus.arvalid = 1'b0;
      rdq.delete();
      return;
    end
    tick();
    bus.arvalid = 1'b0;
    checkOutput("arready_low_after_ar", 32'(bus.arready), 32'd0);
    n = 0;
    while (!bus.rvalid && n < 40) begin tick(); n++; end
    checkOutput("read_latency", 32'(n), 32'(DELAY));
    if (!bus.rvalid) begin
      timeoutFail("first_r_beat");
      rdq.delete();
      return;
    end
    done   = 0;
    n      = 0;
    toggle = 1'b1;
    while (rdq.size() > 0 && n < 200) begin
      if (abortAt >= 0 && done == abortAt) begin
        resetMidBurst();
        rdq.delete();
        return;
      end
      bus.rready = v.stall ? toggle : 1'b1;
      toggle = ~toggle;
      e = rdq[0];
      checkOutput("rvalid_in_burst", 32'(bus.rvalid), 32'd1);
      checkOutput("rdata", bus.rdata, e.data);
      checkOutput("rresp", 32'(bus.rresp), 32'(e.resp));
      checkOutput("rlast", 32'(bus.rlast), 32'(e.last));
      checkOutput("rid", 32'(bus.rid), 32'(e.id));
      if (v.chk_first && done == 0) begin
        checkOutput("first_beat_data", bus.rdata, v.exp_first);
        checkOutput("first_beat_resp", 32'(bus.rresp), 32'(v.exp_resp));
      end
      if (bus.rready) begin
        void'(rdq.pop_front());
        done++;
      end
      tick();
      n++;
    end
    bus.rready = 1'b0;
    if (rdq.size() > 0) begin
      timeoutFail("r_burst_complete");
      rdq.delete();
    end
    checkOutput("beat_count", 32'(done), 32'(int'(v.len) + 1));
    checkOutput("rvalid_after_last", 32'(bus.rvalid), 32'd0);
    checkOutput("arready_after_last", 32'(bus.arready), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.wr) writeBurst(v);
    else      readBurst(v, -1);
  endtask

  initial begin
    vec_t vecs [13];

    vecs[0]  = mkW(4'd1,  BASE + 32'h040,  4'd15, 3'd2, 32'h0000_0000, 4'hF, -1, RESP_OKAY);
    vecs[1]  = mkR(4'd3,  BASE + 32'h040,  4'd15, 1'b0, 1'b1, 32'h0000_0000, RESP_OKAY);
    vecs[2]  = mkW(4'd5,  BASE + 32'h100,  4'd15, 3'd2, 32'h0000_00A0, 4'hF, -1, RESP_OKAY);
    vecs[3]  = mkR(4'd6,  BASE + 32'h100,  4'd15, 1'b0, 1'b1, 32'h0000_00A0, RESP_OKAY);
    vecs[4]  = mkW(4'd2,  BASE + 32'h200,  4'd0,  3'd2, 32'h0000_0000, 4'hF, -1, RESP_OKAY);
    vecs[5]  = mkW(4'd2,  BASE + 32'h203,  4'd0,  3'd0, 32'h1122_3344, 4'h8, -1, RESP_OKAY);
    vecs[6]  = mkR(4'd7,  BASE + 32'h200,  4'd0,  1'b0, 1'b1, 32'h1100_0000, RESP_OKAY);
    vecs[7]  = mkR(4'd8,  BASE + 32'h100,  4'd15, 1'b1, 1'b1, 32'h0000_00A0, RESP_OKAY);
    vecs[8]  = mkR(4'd9,  BASE + 32'h4000, 4'd0,  1'b0, 1'b1, 32'h0000_0000, RESP_SLVERR);
    vecs[9]  = mkW(4'd4,  BASE + 32'h300,  4'd7,  3'd2, 32'h0000_0050, 4'hF, 2, RESP_SLVERR);
    vecs[10] = mkR(4'd10, BASE + 32'h300,  4'd7,  1'b0, 1'b1, 32'h0000_0050, RESP_OKAY);
    vecs[11] = mkW(4'd12, BASE + 32'h3FFC, 4'd1,  3'd2, 32'h0000_0077, 4'hF, -1, RESP_SLVERR);
    vecs[12] = mkR(4'd13, BASE + 32'h3FFC, 4'd1,  1'b0, 1'b1, 32'h0000_0077, RESP_OKAY);

    for (int i = 0; i < WORDS; i++) model[i] = 32'd0;
    idleInputs();

    aresetn = 1'b0;
    tick();
    tick();
    checkOutput("reset_arready", 32'(bus.arready), 32'd0);
    checkOutput("reset_awready", 32'(bus.awready), 32'd0);
    checkOutput("reset_rvalid",  32'(bus.rvalid),  32'd0);
    checkOutput("reset_wready",  32'(bus.wready),  32'd0);
    checkOutput("reset_bvalid",  32'(bus.bvalid),  32'd0);
    checkOutput("reset_rdata",   bus.rdata,        32'd0);
    checkOutput("reset_rlast",   32'(bus.rlast),   32'd0);
    aresetn = 1'b1;
    tick();
    checkOutput("release_arready", 32'(bus.arready), 32'd1);
    checkOutput("release_awready", 32'(bus.awready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      tick();
    end

    $display("[TB] reset during beat 5 of a read burst");
    readBurst(mkR(4'd3, BASE + 32'h040, 4'd15, 1'b0, 1'b0, 32'd0, RESP_OKAY), 4);

    $display("[TB] read after mid-burst reset");
    readBurst(mkR(4'd11, BASE + 32'h100, 4'd3, 1'b0, 1'b1, 32'h0000_00A0, RESP_OKAY), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 responder that terminates the data-cache AXI master port with a word-addressed SRAM model, serving 16-beat cacheline bursts and single-beat uncached accesses. It sits in the simulation and FPGA-bring-up top level in place of the external memory controller. Read and write channels run independent state machines, each with one outstanding transaction.

## Interface
- `ADDR_BASE`, 32'h0000_0000, byte address mapped to word 0
- `MEM_WORDS`, 4096, depth in 32-bit words (power of two)
- `RD_DELAY`, 2, idle cycles between AR handshake and first R beat (0..15)
- `aclk` in 1, sole clock; all logic on its rising edge
- `aresetn` in 1, reset, synchronous, active-low
- `arid`/`awid` in 4, transaction ID, echoed on `rid`/`bid`
- `araddr`/`awaddr` in 32, start byte address
- `arlen`/`awlen` in 4, beats minus one
- `arsize`/`awsize` in 3, bytes per beat = 1<<size (0..2)
- `arburst`/`awburst` in 2, only INCR (2'b01) supported; other values treated as INCR
- `arvalid` in 1 / `arready` out 1, read address handshake
- `rid` out 4, `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1 / `rready` in 1
- `awvalid` in 1 / `awready` out 1, write address handshake
- `wid` in 4 (ignored), `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1 / `wready` out 1
- `bid` out 4, `bresp` out 2, `bvalid` out 1 / `bready` in 1

## Operation
- Read FSM: R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
  - R_IDLE: `arready`=1. On `arvalid&arready` latch id, addr, len, size; load delay counter with `RD_DELAY`; go R_WAIT, or R_DATA directly if `RD_DELAY`=0.
  - R_WAIT: count down to 0, then go R_DATA.
  - R_DATA: `rvalid`=1, `rdata`=mem[word(addr)] (full word regardless of size), `rlast`=(beat==len). On `rvalid&rready`: addr += 1<<size, beat++. Last beat returns to R_IDLE.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: `awready`=1; latch fields on handshake. `wready`=0, so W data presented early by the master is held off.
  - W_DATA: `wready`=1. Each `wvalid&wready` writes bytes of mem[word(addr)] enabled by `wstrb`; addr += 1<<size.
  - The counted beat==len ends the burst; go W_RESP.
  - A `wlast` mismatch on any beat sets a sticky error flag.
  - W_RESP: `bvalid`=1, `bid`=latched id, `bresp`=SLVERR if error else OKAY; on `bready` go W_IDLE and clear the flag.
- Address check: word(a)=(a-ADDR_BASE)>>2. Any beat outside [0,MEM_WORDS) is an error.
  - Read error beat: rdata=0, rresp=SLVERR.
  - Write error beat: write dropped; error flag set.
- A read and a write to the same word in the same cycle: the read returns old data; the write is visible from the next cycle.
- Memory contents are not reset.

## Timing
- While `aresetn`=0 at an edge, after that edge: all outputs 0, both FSMs idle, counters/flags cleared. Reset mid-burst abandons the transaction; no R or B beat is produced for it.
- First cycle after reset release: `arready`=`awready`=1.
- Read latency: AR handshake at edge k -> first `rvalid` in cycle k+1+RD_DELAY. Subsequent beats are back-to-back while `rready`=1.
- `rvalid`, `rdata`, `rlast` and `rresp` are held stable while `rready`=0.
- Write: AW handshake at edge k -> `wready` in cycle k+1.
- Last W handshake at edge m -> `bvalid` in cycle m+1. `bvalid` is held until `bready`.
- `arready`=0 from the AR handshake until the edge completing the last R beat. `awready` is likewise 0 until the B handshake. Back-to-back transactions therefore have one idle cycle with ready high.
- Address arithmetic is 32-bit wrapping; no 4 KB boundary check.

## Structure
- Shared package `axi_pkg`:
  - `RESP_OKAY`=2'b00, `RESP_SLVERR`=2'b10, `BURST_INCR`=2'b01
  - read/write state typedefs, one-hot, 4 bits
- Sub-module `sram_1r1w`: async-read, sync byte-write array of `MEM_WORDS`x32 with 4-bit byte enable; instantiated once.

## Test plan
- Reset then AR(id=3, addr=ADDR_BASE+0x40, len=15, size=2) with `rready`=1 and mem[16+i]=i -> first `rvalid` at handshake+3, 16 beats rdata=0..15, rid=3, `rlast` only on beat 16.
- AW(id=5, addr=0x100, len=15), 16 W beats of 0xA0+i with `wstrb`=F -> bvalid one cycle after last W, bid=5, bresp=OKAY; readback returns 0xA0..0xAF.
- Uncached byte write: AW(len=0, size=0, addr=0x203), wdata=0x11223344, wstrb=8 over an old word of 0 -> word 0x80 reads 0x11000000.
- `rready` toggling 1/0 each cycle during a 16-beat read -> each beat held stable while stalled; 16 beats complete in order.
- AR to ADDR_BASE+4*MEM_WORDS -> rdata=0, rresp=SLVERR. A write burst with `wlast` on beat 3 of len=7 -> bresp=SLVERR after 8 beats.
- `aresetn` low for one edge during beat 5 of a read -> `rvalid`=0 next cycle, `arready`=1 the cycle after reset release, and no stray R beat follows.
